// File: rtl/ma_stage.sv
// RV32I memory-access stage: issues dmem loads/stores over req/ack, holds the pipe while busy,
// and registers results into the MA->WB registers. Optional MA_MISALIGN_CHK_EN blocks misaligned accesses.
module ma_stage #(
  parameter int DMEM_AW = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_ld_ma,
  input  logic               cmd_st_ma,
  input  logic [2:0]         mem_code_ma,
  input  logic [31:0]        rd_data_ma,
  input  logic [31:0]        st_data_ma,
  input  logic               stall,
  input  logic               rst_pipe,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [3:0]         dmem_be,
  output logic [DMEM_AW-1:0] dmem_adr,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  input  logic               dmem_ack,
  output logic               stall_ma,
  output logic               cmd_ld_wb,
  output logic [2:0]         ld_code_wb,
  output logic [31:0]        rd_data_wb,
  output logic [31:0]        ld_data_wb
`ifdef MA_MISALIGN_CHK_EN
  ,
  output logic               misalign_ma
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t      state, state_nxt;
  logic        kill_q;
  logic [31:0] hold_buf;
  logic        mem_op;
  logic        misalign;
  logic        wb_en;
  logic        ld_upd;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  assign mem_op = (cmd_ld_ma | cmd_st_ma) & ~rst_pipe;

`ifdef MA_MISALIGN_CHK_EN
  assign misalign = mem_op &
                    ((((mem_code_ma == 3'b001) | (mem_code_ma == 3'b101)) & rd_data_ma[0]) |
                     ((mem_code_ma == 3'b010) & (rd_data_ma[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Store lane selection and replication of the narrow store data
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = st_data_ma;
    case (mem_code_ma)
      3'b000: begin
        st_be    = 4'b0001 << rd_data_ma[1:0];
        st_wdata = {4{st_data_ma[7:0]}};
      end
      3'b001: begin
        st_be    = rd_data_ma[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data_ma[15:0]}};
      end
      3'b010: begin
        st_be    = 4'b1111;
        st_wdata = st_data_ma;
      end
      default: begin
        st_be    = 4'b0000;
        st_wdata = st_data_ma;
      end
    endcase
  end

  assign dmem_adr   = rd_data_ma[DMEM_AW+1:2];
  assign dmem_we    = cmd_st_ma & ~cmd_ld_ma;
  assign dmem_be    = cmd_ld_ma ? 4'b1111 : (cmd_st_ma ? st_be : 4'b0000);
  assign dmem_wdata = st_wdata;
  assign stall_ma   = dmem_req & ~dmem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dmem_req & dmem_ack)  state_nxt = stall ? HOLD : IDLE;
        else if (dmem_req)        state_nxt = BUSY;
      end
      BUSY: begin
        // A flushed transaction still runs to its ack, but never parks in HOLD
        if (dmem_ack)             state_nxt = (stall & ~kill_q & ~rst_pipe) ? HOLD : IDLE;
      end
      HOLD: begin
        if (rst_pipe | ~stall)    state_nxt = IDLE;
      end
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dmem_req = 1'b0;
    case (state)
      IDLE:    dmem_req = mem_op & ~misalign;
      BUSY:    dmem_req = 1'b1;
      default: dmem_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kill_q   <= 1'b0;
      hold_buf <= 32'h0;
    end else begin
      kill_q <= (state == BUSY) & (kill_q | rst_pipe) & ~dmem_ack;
      if (rst_pipe & (state != BUSY))
        hold_buf <= 32'h0;
      else if (dmem_req & dmem_ack & stall & ~rst_pipe & ~kill_q)
        hold_buf <= dmem_rdata;
    end
  end

  assign wb_en  = ~stall & ~stall_ma & ~((state == BUSY) & kill_q);
  assign ld_upd = wb_en & cmd_ld_ma & ~misalign & ((state == HOLD) | dmem_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ld_wb  <= 1'b0;
      ld_code_wb <= 3'b000;
      rd_data_wb <= 32'h0;
      ld_data_wb <= 32'h0;
    end else if (rst_pipe) begin
      cmd_ld_wb  <= 1'b0;
      ld_code_wb <= 3'b000;
      rd_data_wb <= 32'h0;
    end else if (wb_en) begin
      cmd_ld_wb  <= cmd_ld_ma & ~misalign;
      ld_code_wb <= mem_code_ma;
      rd_data_wb <= rd_data_ma;
      if (ld_upd) ld_data_wb <= (state == HOLD) ? hold_buf : dmem_rdata;
    end
  end

`ifdef MA_MISALIGN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_ma <= 1'b0;
    else     misalign_ma <= misalign & wb_en & (state == IDLE);
  end
`endif

endmodule

// File: doc/ma_stage.md
Name: ma_stage

Overview:
- Memory-access stage of the RV32I pipeline. Sits between EX and the write-back stage.
- Issues loads and stores to the data memory/cache over a req/ack handshake.
- Generates store byte-enables and replicated store data.
- Stalls the pipeline while a transaction is outstanding, then registers results into the MA->WB pipeline registers (cmd_ld_wb, ld_code_wb, rd_data_wb, ld_data_wb).
- Byte/half alignment and sign extension of loads are left to write-back; this stage returns the raw word.

Parameters:
- DMEM_AW, 30, width of the word address driven on dmem_adr (byte address bits [DMEM_AW+1:2]).

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  asynchronous active-high reset
- cmd_ld_ma  input  1  load in MA
- cmd_st_ma  input  1  store in MA
- mem_code_ma  input  3  funct3 of load/store
- rd_data_ma  input  32  ALU result; the byte address for ld/st
- st_data_ma  input  32  rs2 store data
- stall  input  1  global stall from the other stages
- rst_pipe  input  1  pipeline flush
- dmem_req  output  1  memory request
- dmem_we  output  1  1 = write
- dmem_be  output  4  byte enables
- dmem_adr  output  DMEM_AW  word address
- dmem_wdata  output  32  aligned store data
- dmem_rdata  input  32  read data; valid with dmem_ack
- dmem_ack  input  1  transaction complete
- stall_ma  output  1  MA busy; ORed into the global stall by the top level
- cmd_ld_wb  output  1  registered load flag to WB
- ld_code_wb  output  3  registered funct3 to WB
- rd_data_wb  output  32  registered ALU result / address to WB
- ld_data_wb  output  32  registered raw load word to WB

Behaviour:
- Reset: all WB outputs are 0, the FSM is IDLE, and hold_buf is 0.
- Memory op present: mem_op = (cmd_ld_ma | cmd_st_ma) & ~rst_pipe.
- Address: dmem_adr = rd_data_ma[DMEM_AW+1:2].
- Loads: dmem_we=0, dmem_be=4'b1111.
- Stores, by funct3:
  - SB (000): be = 4'b0001 << adr[1:0]; wdata = {4{st_data[7:0]}}.
  - SH (001): be = adr[1] ? 4'b1100 : 4'b0011; wdata = {2{st_data[15:0]}}.
  - SW (010): be = 4'b1111; wdata = st_data.
  - Any other code: be = 0.
- All dmem_* outputs are combinational from the stage inputs. Inputs are held stable by the global stall while the stage is busy.
- stall_ma = dmem_req & ~dmem_ack.
- FSM state IDLE:
  - dmem_req = mem_op.
  - ack & ~stall: results go to the WB registers; stay IDLE. Zero-wait memory gives 0 extra cycles.
  - ack & stall: capture dmem_rdata into hold_buf; go to HOLD.
  - mem_op & ~ack: go to BUSY.
- FSM state BUSY:
  - dmem_req = 1; request fields stay constant.
  - On ack: same two exits as IDLE (to IDLE, or to HOLD when stall).
- FSM state HOLD:
  - dmem_req = 0 and stall_ma = 0. The access has completed and is never re-issued, so there are no double stores.
  - When ~stall: WB registers take hold_buf; go to IDLE.
- WB register update: enabled when ~stall & ~stall_ma, or on the HOLD exit.
  - cmd_ld_wb, ld_code_wb and rd_data_wb take the MA inputs.
  - ld_data_wb takes the read data (or hold_buf) only for a completed load; otherwise it keeps its value.
  - Non-memory instructions pass through with 0 added latency.
- rst_pipe in IDLE or HOLD: WB registers are cleared to 0, state goes to IDLE, no request is issued, and hold_buf is discarded.
- rst_pipe in BUSY: the transaction cannot be aborted.
  - dmem_req stays high until ack, then the FSM returns to IDLE.
  - The result is discarded and WB registers are cleared on the rst_pipe cycle.
  - stall_ma stays asserted until ack.
- Async rst mid-transaction drops dmem_req immediately. The memory side must tolerate an abandoned request.
- Simultaneous ack and rst_pipe in IDLE: impossible, because dmem_req=0.

Optional Feature:
- Macro: MA_MISALIGN_CHK_EN.
- When defined:
  - Adds output misalign_ma (1 bit) and suppresses dmem_req for a misaligned access: SH/LH/LHU with adr[0]=1, or SW/LW with adr[1:0]!=0.
  - misalign_ma is a 1-cycle pulse, registered, asserted the cycle after detection.
  - The instruction proceeds to WB with cmd_ld_wb=0.
- When undefined: no port; low address bits outside the be rules are ignored and the access proceeds.

Test Plan:
- SW, adr 0x100, data 0xDEADBEEF, ack same cycle -> req=1, we=1, be=1111, adr=0x40, wdata=0xDEADBEEF, stall_ma=0; rd_data_wb=0x100 next edge.
- SB, adr 0x103, data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5. SH, adr 0x102, data 0x1234 -> be=1100, wdata=0x12341234.
- LW, adr 0x20, ack after 3 cycles with rdata 0x80FF0011 -> stall_ma=1 for 3 cycles; cmd_ld_wb=1, ld_data_wb=0x80FF0011, ld_code_wb=010 one edge after ack.
- SW acked while stall=1 for 2 more cycles -> exactly one req/ack; dmem_req=0 in HOLD; WB regs update on the first cycle after stall drops.
- LW in BUSY with rst_pipe pulsed -> req held until ack; cmd_ld_wb=0 and ld_data_wb unchanged; IDLE afterwards. Async rst mid-BUSY -> req=0 and all WB outputs 0 immediately.
- With MA_MISALIGN_CHK_EN: LW, adr 0x102 -> dmem_req=0, misalign_ma=1 for one cycle, cmd_ld_wb=0.
